// File: rtl/cache_ctrl_sa.sv
`timescale 1ns/1ps
// Set-associative write-back/write-allocate data cache controller.
// Tags and lines are held in registers; a line-wide req/ack port handles misses.
module cache_ctrl_sa #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int WAYS       = 4,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_req,
  output logic                             cpu_ready,
  input  logic                             cpu_we,
  input  logic [ADDR_WIDTH-1:0]            cpu_addr,
  input  logic [WORD_WIDTH-1:0]            cpu_wdata,
  input  logic [WORD_WIDTH/8-1:0]          cpu_be,
  output logic                             cpu_resp_valid,
  output logic [WORD_WIDTH-1:0]            cpu_rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] mem_wdata,
  input  logic                             mem_ack,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]             hit_cnt,
  output logic [CNT_WIDTH-1:0]             miss_cnt
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int BOFF  = $clog2(BYTES);
  localparam int WOFF  = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = ADDR_WIDTH - IDX - WOFF - BOFF;
  localparam int LINE  = LINE_WORDS * WORD_WIDTH;
  localparam int WAYB  = $clog2(WAYS);
  localparam int IDXW  = (IDX > 0) ? IDX : 1;
  localparam int WRDW  = (WOFF > 0) ? WOFF : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, REFILL} state_t;

  state_t                  state_r, state_n;
  logic                    req_we_r;
  logic [ADDR_WIDTH-1:0]   req_addr_r;
  logic [WORD_WIDTH-1:0]   req_wdata_r;
  logic [BYTES-1:0]        req_be_r;
  logic                    first_r;
  logic [WAYB-1:0]         victim_r;
  logic                    victim_rr_r;
  logic                    resp_valid_r;
  logic [WORD_WIDTH-1:0]   rdata_r;
  logic                    mem_req_r, mem_req_n;
  logic                    mem_we_r, mem_we_n;
  logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_n;
  logic [LINE-1:0]         mem_wdata_r, mem_wdata_n;
  logic [CNT_WIDTH-1:0]    hit_cnt_r, miss_cnt_r;

  logic                    valid_r [SETS][WAYS];
  logic                    dirty_r [SETS][WAYS];
  logic [TAG-1:0]          tag_r   [SETS][WAYS];
  logic [LINE-1:0]         line_r  [SETS][WAYS];
  logic [WAYB-1:0]         rr_r    [SETS];

  logic [TAG-1:0]          tag_s;
  logic [IDXW-1:0]         idx_s;
  logic [WRDW-1:0]         word_s;
  logic                    hit_s, inv_s;
  logic [WAYB-1:0]         hit_way_s, inv_way_s, victim_s;
  logic [WORD_WIDTH-1:0]   hit_word_s, resp_word_s;

  function automatic logic [WORD_WIDTH-1:0] merge_bytes(
    input logic [WORD_WIDTH-1:0] old_w,
    input logic [WORD_WIDTH-1:0] new_w,
    input logic [BYTES-1:0]      be
  );
    logic [WORD_WIDTH-1:0] m;
    m = old_w;
    for (int b = 0; b < BYTES; b++) begin
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
      else       m[8*b +: 8] = old_w[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] line_addr(
    input logic [TAG-1:0]  t,
    input logic [IDXW-1:0] i
  );
    logic [ADDR_WIDTH-1:0] a;
    a = ADDR_WIDTH'(t) << (IDX + WOFF + BOFF);
    if (SETS > 1) a = a | (ADDR_WIDTH'(i) << (WOFF + BOFF));
    else          a = a;
    return a;
  endfunction

  assign tag_s  = req_addr_r[ADDR_WIDTH-1 -: TAG];
  assign idx_s  = (SETS > 1) ? IDXW'(req_addr_r >> (BOFF + WOFF)) : {IDXW{1'b0}};
  assign word_s = (LINE_WORDS > 1) ? WRDW'(req_addr_r >> BOFF) : {WRDW{1'b0}};

  // Tag match and victim choice; descending scan so the lowest index wins.
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = {WAYB{1'b0}};
    inv_s     = 1'b0;
    inv_way_s = {WAYB{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_r[idx_s][w] && (tag_r[idx_s][w] == tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAYB'(w);
      end else begin
        hit_s     = hit_s;
      end
      if (!valid_r[idx_s][w]) begin
        inv_s     = 1'b1;
        inv_way_s = WAYB'(w);
      end else begin
        inv_s     = inv_s;
      end
    end
    victim_s    = inv_s ? inv_way_s : rr_r[idx_s];
    hit_word_s  = line_r[idx_s][hit_way_s][word_s*WORD_WIDTH +: WORD_WIDTH];
    resp_word_s = req_we_r ? merge_bytes(hit_word_s, req_wdata_r, req_be_r) : hit_word_s;
  end

  // Next state and next memory-port values; port values hold until mem_ack.
  always_comb begin
    state_n     = state_r;
    mem_req_n   = mem_req_r;
    mem_we_n    = mem_we_r;
    mem_addr_n  = mem_addr_r;
    mem_wdata_n = mem_wdata_r;
    case (state_r)
      IDLE: begin
        if (cpu_req) state_n = LOOKUP;
        else         state_n = IDLE;
      end
      LOOKUP: begin
        if (hit_s) begin
          state_n = IDLE;
        end else if (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) begin
          state_n     = WB;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = line_addr(tag_r[idx_s][victim_s], idx_s);
          mem_wdata_n = line_r[idx_s][victim_s];
        end else begin
          state_n    = REFILL;
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = line_addr(tag_s, idx_s);
        end
      end
      WB: begin
        if (mem_ack) begin
          state_n    = REFILL;
          mem_we_n   = 1'b0;
          mem_addr_n = line_addr(tag_s, idx_s);
        end else begin
          state_n = WB;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          state_n   = LOOKUP;
          mem_req_n = 1'b0;
        end else begin
          state_n = REFILL;
        end
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
      end
    endcase
  end

  // Control state, request capture, metadata, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      req_we_r     <= 1'b0;
      req_addr_r   <= {ADDR_WIDTH{1'b0}};
      req_wdata_r  <= {WORD_WIDTH{1'b0}};
      req_be_r     <= {BYTES{1'b0}};
      first_r      <= 1'b0;
      victim_r     <= {WAYB{1'b0}};
      victim_rr_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      rdata_r      <= {WORD_WIDTH{1'b0}};
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {LINE{1'b0}};
      hit_cnt_r    <= {CNT_WIDTH{1'b0}};
      miss_cnt_r   <= {CNT_WIDTH{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        rr_r[s] <= {WAYB{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          dirty_r[s][w] <= 1'b0;
        end
      end
    end else begin
      state_r      <= state_n;
      mem_req_r    <= mem_req_n;
      mem_we_r     <= mem_we_n;
      mem_addr_r   <= mem_addr_n;
      mem_wdata_r  <= mem_wdata_n;
      resp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cpu_req) begin
            req_we_r    <= cpu_we;
            req_addr_r  <= cpu_addr;
            req_wdata_r <= cpu_wdata;
            req_be_r    <= cpu_be;
            first_r     <= 1'b1;
          end
        end
        LOOKUP: begin
          first_r <= 1'b0;
          if (hit_s) begin
            resp_valid_r <= 1'b1;
            rdata_r      <= resp_word_s;
            if (req_we_r) dirty_r[idx_s][hit_way_s] <= 1'b1;
            if (first_r && (hit_cnt_r != {CNT_WIDTH{1'b1}}))
              hit_cnt_r <= hit_cnt_r + CNT_WIDTH'(1);
          end else begin
            victim_r    <= victim_s;
            victim_rr_r <= !inv_s;
            if (first_r && (miss_cnt_r != {CNT_WIDTH{1'b1}}))
              miss_cnt_r <= miss_cnt_r + CNT_WIDTH'(1);
          end
        end
        REFILL: begin
          if (mem_ack) begin
            valid_r[idx_s][victim_r] <= 1'b1;
            dirty_r[idx_s][victim_r] <= 1'b0;
            if (victim_rr_r) rr_r[idx_s] <= rr_r[idx_s] + WAYB'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and line storage; only written from LOOKUP (store hit) or REFILL (fill).
  always_ff @(posedge clk) begin
    if (state_r == LOOKUP && hit_s && req_we_r) begin
      line_r[idx_s][hit_way_s][word_s*WORD_WIDTH +: WORD_WIDTH] <= resp_word_s;
    end else if (state_r == REFILL && mem_ack) begin
      line_r[idx_s][victim_r] <= mem_rdata;
      tag_r[idx_s][victim_r]  <= tag_s;
    end
  end

  assign cpu_ready      = (state_r == IDLE);
  assign cpu_resp_valid = resp_valid_r;
  assign cpu_rdata      = rdata_r;
  assign mem_req        = mem_req_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wdata      = mem_wdata_r;
  assign hit_cnt        = hit_cnt_r;
  assign miss_cnt       = miss_cnt_r;

endmodule

// File: tb/tb_cache_ctrl_sa.sv
`timescale 1ns/1ps
// Directed bench for cache_ctrl_sa: default geometry plus a CNT_WIDTH=4 twin
// driven by the same stimulus to observe counter saturation.
module tb_cache_ctrl_sa;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata;
  logic [3:0]   cpu_be;
  logic         cpu_ready, cpu_resp_valid;
  logic [31:0]  cpu_rdata;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [15:0]  hit_cnt, miss_cnt;

  logic         cpu_ready4, cpu_resp_valid4, mem_req4, mem_we4;
  logic [31:0]  cpu_rdata4, mem_addr4;
  logic [127:0] mem_wdata4;
  logic [3:0]   hit_cnt4, miss_cnt4;

  int n_checks = 0;
  int n_errors = 0;
  int ack_delay = 0;

  logic         txn_we    [$];
  logic [31:0]  txn_addr  [$];
  logic [127:0] txn_wdata [$];

  always #5 clk = ~clk;

  cache_ctrl_sa dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_ctrl_sa #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_ready(cpu_ready4), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_resp_valid(cpu_resp_valid4), .cpu_rdata(cpu_rdata4),
    .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
  );

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] line_for(input logic [31:0] a);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = 32'hA500_0000 | (a + 32'(4 * i));
    return l;
  endfunction

  // Memory model: acks after ack_delay waiting cycles, logs completed transactions
  // and checks that the request stays stable while it waits.
  initial begin
    logic         in_txn;
    logic         cap_we;
    logic [31:0]  cap_addr;
    logic [127:0] cap_wdata;
    int           cnt;
    mem_ack   = 1'b0;
    mem_rdata = 128'h0;
    in_txn    = 1'b0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        in_txn  = 1'b0;
        cnt     = 0;
      end
      if (!mem_req) begin
        in_txn  = 1'b0;
        cnt     = 0;
      end else begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          cap_we    = mem_we;
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
        end else begin
          check_eq("mem_stable", {mem_we, mem_addr, mem_wdata}, {cap_we, cap_addr, cap_wdata});
        end
        if (cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = line_for(cap_addr);
          txn_we.push_back(cap_we);
          txn_addr.push_back(cap_addr);
          txn_wdata.push_back(cap_wdata);
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output int lat);
    logic got;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    got = 1'b0; lat = 0; rdata = 32'h0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_resp_valid) begin
        got   = 1'b1;
        rdata = cpu_rdata;
      end else begin
        check_eq("ready_busy", cpu_ready, 1'b0);
      end
    end
    if (!got) check_eq("resp_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat, n0;
    logic        seen;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_be = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", cpu_ready, 1'b1);
    check_eq("rst_resp", cpu_resp_valid, 1'b0);
    check_eq("rst_rdata", cpu_rdata, 32'h0);
    check_eq("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 161'h0);
    check_eq("rst_cnt", {hit_cnt, miss_cnt}, 32'h0);

    // Cold load, then hit load and byte-enable store on the same line
    n0 = txn_addr.size();
    access(1'b0, 32'h100, 32'h0, 4'h0, rd, lat);
    check_eq("cold_rdata", rd, 32'hA500_0100);
    check_eq("cold_lat", lat, 4);
    check_eq("cold_ntxn", txn_addr.size() - n0, 1);
    check_eq("cold_txn", {txn_we[n0], txn_addr[n0]}, {1'b0, 32'h100});
    check_eq("cold_cnt", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
    n0 = txn_addr.size();
    access(1'b0, 32'h104, 32'h0, 4'h0, rd, lat);
    check_eq("hit_rdata", rd, 32'hA500_0104);
    check_eq("hit_lat", lat, 2);
    check_eq("hit_cnt", hit_cnt, 16'd1);
    access(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, rd, lat);
    check_eq("st_rdata", rd, 32'hA500_BEEF);
    access(1'b0, 32'h104, 32'h0, 4'h0, rd, lat);
    check_eq("st_reload", rd, 32'hA500_BEEF);
    check_eq("hit_no_mem", txn_addr.size() - n0, 0);

    // Fill the remaining ways of set 16 and dirty them
    access(1'b0, 32'h500, 32'h0, 4'h0, rd, lat);
    access(1'b0, 32'h900, 32'h0, 4'h0, rd, lat);
    access(1'b0, 32'hD00, 32'h0, 4'h0, rd, lat);
    check_eq("fill_rdata", rd, 32'hA500_0D00);
    access(1'b1, 32'h500, 32'h1111_1111, 4'b1111, rd, lat);
    check_eq("st500", rd, 32'h1111_1111);
    access(1'b1, 32'h908, 32'h2222_2222, 4'b1100, rd, lat);
    check_eq("st908", rd, 32'h2222_0908);
    access(1'b1, 32'hD0C, 32'h3333_3333, 4'b0100, rd, lat);
    check_eq("stD0C", rd, 32'hA533_0D0C);

    // Fifth tag evicts way 0 with write-back, then the pointer selects way 1
    n0 = txn_addr.size();
    ack_delay = 2;
    access(1'b0, 32'h1100, 32'h0, 4'h0, rd, lat);
    check_eq("ev1_rdata", rd, 32'hA500_1100);
    check_eq("ev1_ntxn", txn_addr.size() - n0, 2);
    check_eq("ev1_wb", {txn_we[n0], txn_addr[n0], txn_wdata[n0]},
             {1'b1, 32'h100, 128'hA500_010C_A500_0108_A500_BEEF_A500_0100});
    check_eq("ev1_rf", {txn_we[n0+1], txn_addr[n0+1]}, {1'b0, 32'h1100});
    n0 = txn_addr.size();
    ack_delay = 0;
    access(1'b0, 32'h1500, 32'h0, 4'h0, rd, lat);
    check_eq("ev2_rdata", rd, 32'hA500_1500);
    check_eq("ev2_wb", {txn_we[n0], txn_addr[n0], txn_wdata[n0]},
             {1'b1, 32'h500, 128'hA500_050C_A500_0508_A500_0504_1111_1111});
    check_eq("ev2_rf", {txn_we[n0+1], txn_addr[n0+1]}, {1'b0, 32'h1500});

    // Slow refill: 7 waiting cycles
    ack_delay = 7;
    access(1'b0, 32'h2000, 32'h0, 4'h0, rd, lat);
    check_eq("slow_rdata", rd, 32'hA500_2000);
    check_eq("slow_lat", lat, 11);
    check_eq("slow_cnt", {hit_cnt, miss_cnt}, {16'd6, 16'd7});
    check_eq("slow_cnt4", {hit_cnt4, miss_cnt4}, {4'd6, 4'd7});

    // Reset while writing back the dirty way 2 (tag address 0x900)
    ack_delay = 5;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1900;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) seen = 1'b1;
    end
    check_eq("wb_start", {seen, mem_addr}, {1'b1, 32'h900});
    #2 rst = 1'b1;
    #1 check_eq("rst_mem_req", mem_req, 1'b0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    ack_delay = 0;
    check_eq("rst2_cnt", {hit_cnt, miss_cnt, hit_cnt4, miss_cnt4}, 40'h0);
    check_eq("rst2_ready", cpu_ready, 1'b1);
    n0 = txn_addr.size();
    access(1'b0, 32'h1100, 32'h0, 4'h0, rd, lat);
    check_eq("rst2_miss", {txn_addr.size() - n0, miss_cnt}, {32'd1, 16'd1});
    check_eq("rst2_txn", {txn_we[n0], txn_addr[n0]}, {1'b0, 32'h1100});

    // 20 hits: 16-bit counter reaches 20, 4-bit counter saturates at 15
    for (int i = 0; i < 20; i++) access(1'b0, 32'h1104, 32'h0, 4'h0, rd, lat);
    check_eq("sat_rdata", rd, 32'hA500_1104);
    check_eq("sat_cnt16", {hit_cnt, miss_cnt}, {16'd20, 16'd1});
    check_eq("sat_cnt4", {hit_cnt4, miss_cnt4}, {4'd15, 4'd1});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
